// File: rtl/lampfpu_div_iter.sv
// Iterative floating-point divider with a radix-2 restoring mantissa core.
// Operands are IEEE-style {sign, exponent, fraction}; results never go subnormal.
module lampfpu_div_iter #(
  parameter int unsigned E_DW = 8,
  parameter int unsigned F_DW = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 flush_i,
  input  logic                 padv_i,
  input  logic                 rnd_mode_i,
  input  logic [E_DW+F_DW:0]   op1_i,
  input  logic [E_DW+F_DW:0]   op2_i,
  output logic [E_DW+F_DW:0]   result_o,
  output logic [4:0]           flags_o,
  output logic                 valid_o,
  output logic                 ready_o,
  output logic                 busy_o
);

  localparam int unsigned DW  = 1 + E_DW + F_DW;
  localparam int unsigned M   = F_DW + 1;         // significand incl. hidden bit
  localparam int unsigned QW  = F_DW + 3;         // significand + guard + round
  localparam int unsigned EW  = E_DW + 2;         // signed working exponent
  localparam int unsigned LZW = $clog2(F_DW + 1);
  localparam int unsigned CW  = $clog2(QW + 1);

  localparam logic [EW-1:0] BIAS = EW'((1 << (E_DW - 1)) - 1);
  localparam logic [EW-1:0] EMAX = EW'((1 << E_DW) - 1);
  localparam logic [DW-1:0] QNAN = {1'b0, {E_DW{1'b1}}, 1'b1, {(F_DW-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StPrep, StIter, StRound, StDone} state_e;

  typedef struct packed {
    logic          s;
    logic          zero;
    logic          inf;
    logic          nan;
    logic          snan;
    logic [EW-1:0] e;
    logic [M-1:0]  m;
  } unp_t;

  // Split an operand; subnormals come back normalised with a negative exponent.
  function automatic unp_t unpack(input logic [DW-1:0] x);
    unp_t            u;
    logic [E_DW-1:0] ef;
    logic [F_DW-1:0] fr;
    logic [LZW-1:0]  lz;
    ef = x[DW-2:F_DW];
    fr = x[F_DW-1:0];
    lz = '0;
    for (int i = 0; i < F_DW; i++) begin
      if (fr[i]) lz = LZW'(F_DW - 1 - i);
    end
    u.s    = x[DW-1];
    u.zero = (ef == '0) && (fr == '0);
    u.inf  = (&ef) && (fr == '0);
    u.nan  = (&ef) && (fr != '0);
    u.snan = u.nan && !fr[F_DW-1];
    if (ef == '0) begin
      u.m = {1'b0, fr} << (lz + LZW'(1));
      u.e = EW'(0) - EW'(lz);
    end else begin
      u.m = {1'b1, fr};
      u.e = EW'(ef);
    end
    return u;
  endfunction

  state_e         state_q;
  logic [DW-1:0]  opa_q, opb_q, result_q, spec_res_q;
  logic [4:0]     flags_q, spec_flg_q;
  logic           rnd_q, sgn_q, spec_q, valid_q;
  logic [EW-1:0]  exp_q;
  logic [M:0]     rem_q;
  logic [M-1:0]   div_q;
  logic [QW-1:0]  q_q;
  logic [CW-1:0]  cnt_q;

  unp_t           ua, ub;
  logic           sgn_d, spec_d;
  logic [DW-1:0]  spec_res_d, rnd_res_d;
  logic [4:0]     spec_flg_d, rnd_flg_d;
  logic [EW-1:0]  exp_d;
  logic [M:0]     rem_d, rem_it_d;
  logic [QW-1:0]  q_it_d;

  // Operand classification, special-case result and initial divider state.
  always_comb begin
    ua         = unpack(opa_q);
    ub         = unpack(opb_q);
    sgn_d      = ua.s ^ ub.s;
    spec_d     = 1'b1;
    spec_res_d = '0;
    spec_flg_d = '0;
    if (ua.nan || ub.nan) begin
      spec_res_d    = QNAN;
      spec_flg_d[4] = ua.snan | ub.snan;
    end else if ((ua.zero && ub.zero) || (ua.inf && ub.inf)) begin
      spec_res_d = QNAN;
      spec_flg_d = 5'b10000;
    end else if (ua.inf) begin
      spec_res_d = {sgn_d, {E_DW{1'b1}}, {F_DW{1'b0}}};
    end else if (ub.zero) begin
      spec_res_d = {sgn_d, {E_DW{1'b1}}, {F_DW{1'b0}}};
      spec_flg_d = 5'b01000;
    end else if (ua.zero || ub.inf) begin
      spec_res_d = {sgn_d, {(DW-1){1'b0}}};
    end else begin
      spec_d = 1'b0;
    end
    exp_d = ua.e - ub.e + BIAS;
    // Pre-scale so the quotient lands in [1,2) and its first bit is always 1.
    if (ua.m < ub.m) begin
      rem_d = {ua.m, 1'b0};
      exp_d = exp_d - EW'(1);
    end else begin
      rem_d = {1'b0, ua.m};
    end
  end

  // One restoring-division step.
  always_comb begin
    logic ge;
    ge       = rem_q >= {1'b0, div_q};
    rem_it_d = (ge ? rem_q - {1'b0, div_q} : rem_q) << 1;
    q_it_d   = {q_q[QW-2:0], ge};
  end

  // Rounding, renormalisation and overflow/underflow packing.
  always_comb begin
    logic          g, r, st, inc, nx;
    logic [M:0]    sum;
    logic [EW-1:0] e;
    logic [F_DW-1:0] frac;
    g    = q_q[1];
    r    = q_q[0];
    st   = rem_q != '0;
    nx   = g | r | st;
    inc  = !rnd_q && g && (r || st || q_q[2]);
    sum  = {1'b0, q_q[QW-1:2]} + {{M{1'b0}}, inc};
    frac = sum[M] ? '0 : sum[F_DW-1:0];
    e    = exp_q + {{(EW-1){1'b0}}, sum[M]};
    if (!e[EW-1] && (e >= EMAX)) begin
      rnd_res_d = rnd_q ? {sgn_q, {(E_DW-1){1'b1}}, 1'b0, {F_DW{1'b1}}}
                        : {sgn_q, {E_DW{1'b1}}, {F_DW{1'b0}}};
      rnd_flg_d = 5'b00101;
    end else if (e[EW-1] || (e == '0)) begin
      rnd_res_d = {sgn_q, {(DW-1){1'b0}}};
      rnd_flg_d = 5'b00011;
    end else begin
      rnd_res_d = {sgn_q, e[E_DW-1:0], frac};
      rnd_flg_d = {4'b0000, nx};
    end
  end

  // Control FSM and datapath registers; flush overrides every other request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      opa_q      <= '0;
      opb_q      <= '0;
      rnd_q      <= 1'b0;
      sgn_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      spec_flg_q <= '0;
      exp_q      <= '0;
      rem_q      <= '0;
      div_q      <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      flags_q    <= '0;
      valid_q    <= 1'b0;
    end else if (flush_i) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            opa_q   <= op1_i;
            opb_q   <= op2_i;
            rnd_q   <= rnd_mode_i;
            state_q <= StPrep;
          end
        end
        StPrep: begin
          sgn_q  <= sgn_d;
          spec_q <= spec_d;
          if (spec_d) begin
            // Specials retire through ROUND so result_o is only written there.
            spec_res_q <= spec_res_d;
            spec_flg_q <= spec_flg_d;
            state_q    <= StRound;
          end else begin
            exp_q   <= exp_d;
            rem_q   <= rem_d;
            div_q   <= ub.m;
            q_q     <= '0;
            cnt_q   <= CW'(QW);
            state_q <= StIter;
          end
        end
        StIter: begin
          rem_q <= rem_it_d;
          q_q   <= q_it_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= StRound;
        end
        StRound: begin
          result_q <= spec_q ? spec_res_q : rnd_res_d;
          flags_q  <= spec_q ? spec_flg_q : rnd_flg_d;
          valid_q  <= 1'b1;
          state_q  <= StDone;
        end
        StDone: begin
          if (start_i) begin
            opa_q   <= op1_i;
            opb_q   <= op2_i;
            rnd_q   <= rnd_mode_i;
            valid_q <= 1'b0;
            state_q <= StPrep;
          end else if (padv_i) begin
            valid_q <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign result_o = result_q;
  assign flags_o  = flags_q;
  assign valid_o  = valid_q;
  assign ready_o  = (state_q == StIdle) || (state_q == StDone);
  assign busy_o   = (state_q == StPrep) || (state_q == StIter) || (state_q == StRound);

endmodule

// File: tb/tb_lampfpu_div_iter.sv
// Bench for lampfpu_div_iter (binary32 defaults): directed table, random ops
// against an arithmetic reference, and handshake/flush/reset sequences.
module tb_lampfpu_div_iter;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, flush_i, padv_i, rnd_mode_i;
  logic [31:0] op1_i, op2_i, result_o;
  logic [4:0]  flags_o;
  logic        valid_o, ready_o, busy_o;

  int nvec = 0;
  int nerr = 0;

  lampfpu_div_iter dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .flush_i   (flush_i),
    .padv_i    (padv_i),
    .rnd_mode_i(rnd_mode_i),
    .op1_i     (op1_i),
    .op2_i     (op2_i),
    .result_o  (result_o),
    .flags_o   (flags_o),
    .valid_o   (valid_o),
    .ready_o   (ready_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        rnd;
    logic [31:0] r;
    logic [4:0]  f;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Exact quotient from integer division, then round-to-nearest-even or truncate.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic rnd,
                                  output logic [31:0] r, output logic [4:0] f, output int lat);
    logic s;
    int ea, eb, xa, xb, p, sh, ex;
    logic [22:0] fa, fb;
    bit nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zero_a, zero_b, nx, up;
    longint unsigned ma, mb, num, q, rm, sig, drop, half;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    fa = a[22:0];        fb = b[22:0];
    s  = a[31] ^ b[31];
    nan_a  = (ea == 255) && (fa != 0); nan_b = (eb == 255) && (fb != 0);
    snan_a = nan_a && !fa[22];         snan_b = nan_b && !fb[22];
    inf_a  = (ea == 255) && (fa == 0); inf_b = (eb == 255) && (fb == 0);
    zero_a = (ea == 0) && (fa == 0);   zero_b = (eb == 0) && (fb == 0);
    r = '0; f = '0; lat = 2;
    if (nan_a || nan_b) begin
      r = QNAN; f[4] = snan_a || snan_b;
    end else if ((zero_a && zero_b) || (inf_a && inf_b)) begin
      r = QNAN; f = 5'b10000;
    end else if (inf_a) begin
      r = {s, 8'hFF, 23'h0};
    end else if (zero_b) begin
      r = {s, 8'hFF, 23'h0}; f = 5'b01000;
    end else if (zero_a || inf_b) begin
      r = {s, 31'h0};
    end else begin
      lat = 28;
      ma = 64'(fa); if (ea != 0) ma |= 64'h80_0000;
      mb = 64'(fb); if (eb != 0) mb |= 64'h80_0000;
      xa = (ea == 0 ? 1 : ea) - 150;
      xb = (eb == 0 ? 1 : eb) - 150;
      while (ma < 64'h80_0000) begin ma = ma << 1; xa--; end
      while (mb < 64'h80_0000) begin mb = mb << 1; xb--; end
      num = ma << 40;
      q   = num / mb;
      rm  = num % mb;
      p = 63;
      while (p > 0 && !q[p]) p--;
      sh   = p - 23;
      sig  = q >> sh;
      drop = q & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      nx   = (drop != 0) || (rm != 0);
      up   = !rnd && ((drop > half) || (drop == half && (rm != 0 || sig[0])));
      if (up) sig = sig + 1;
      ex = p + xa - xb - 40 + 127;
      if (sig == (64'd1 << 24)) begin sig = sig >> 1; ex++; end
      if (ex >= 255) begin
        r = rnd ? {s, 8'hFE, 23'h7FFFFF} : {s, 8'hFF, 23'h0};
        f = 5'b00101;
      end else if (ex <= 0) begin
        r = {s, 31'h0};
        f = 5'b00011;
      end else begin
        r = {s, ex[7:0], sig[22:0]};
        f = {4'b0000, nx};
      end
    end
  endfunction

  function automatic logic [31:0] rand_op();
    logic       s;
    logic [22:0] fr;
    logic [7:0] e;
    s  = 1'($urandom_range(0, 1));
    fr = 23'($urandom);
    case ($urandom_range(0, 15))
      0:       return {s, 31'h0};
      1:       return {s, 8'hFF, 23'h0};
      2:       return {s, 8'hFF, fr | 23'h1};
      3:       return {s, 8'h00, fr};
      4, 5:    begin e = 8'($urandom_range(1, 254)); return {s, e, fr}; end
      default: begin e = 8'($urandom_range(100, 154)); return {s, e, fr}; end
    endcase
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic rnd);
    @(negedge clk);
    op1_i = a; op2_i = b; rnd_mode_i = rnd; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // Counts edges from the accept edge until valid_o, bounded.
  task automatic wait_valid(output int lat, output logic busy_ok);
    lat = 0; busy_ok = 1'b1;
    while (!valid_o && lat < 100) begin
      if (!busy_o) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_op();
    @(negedge clk); padv_i = 1'b1;
    @(posedge clk); #1; padv_i = 1'b0;
  endtask

  initial begin
    logic [31:0] er, r0;
    logic [4:0]  ef;
    int          el, lat, seen;
    logic        bok, stable;

    rst = 1'b0; start_i = 1'b0; flush_i = 1'b0; padv_i = 1'b0; rnd_mode_i = 1'b0;
    op1_i = '0; op2_i = '0;

    tbl.push_back('{32'h40C00000, 32'h40000000, 1'b0, 32'h40400000, 5'b00000, 28});
    tbl.push_back('{32'h3F800000, 32'h40400000, 1'b0, 32'h3EAAAAAB, 5'b00001, 28});
    tbl.push_back('{32'h3F800000, 32'h40400000, 1'b1, 32'h3EAAAAAA, 5'b00001, 28});
    tbl.push_back('{32'h3F800000, 32'h00000000, 1'b0, 32'h7F800000, 5'b01000, 2});
    tbl.push_back('{32'h00000000, 32'h00000000, 1'b0, 32'h7FC00000, 5'b10000, 2});
    tbl.push_back('{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 5'b10000, 2});
    tbl.push_back('{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 5'b00000, 2});
    tbl.push_back('{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 5'b10000, 2});
    tbl.push_back('{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 5'b00000, 2});
    tbl.push_back('{32'h7F800000, 32'h00000000, 1'b0, 32'h7F800000, 5'b00000, 2});
    tbl.push_back('{32'h80000000, 32'h40000000, 1'b0, 32'h80000000, 5'b00000, 2});
    tbl.push_back('{32'h3F800000, 32'hFF800000, 1'b0, 32'h80000000, 5'b00000, 2});
    tbl.push_back('{32'h7F7FFFFF, 32'h3F000000, 1'b0, 32'h7F800000, 5'b00101, 28});
    tbl.push_back('{32'h7F7FFFFF, 32'h3F000000, 1'b1, 32'h7F7FFFFF, 5'b00101, 28});
    tbl.push_back('{32'h00400000, 32'h3F000000, 1'b0, 32'h00800000, 5'b00000, 28});
    tbl.push_back('{32'h00800000, 32'h40000000, 1'b0, 32'h00000000, 5'b00011, 28});

    // Reset state
    #22;
    check("rst_result", result_o, 32'h0);
    check("rst_flags", 32'(flags_o), 32'h0);
    check("rst_valid", 32'(valid_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_ready", 32'(ready_o), 32'h1);
    @(negedge clk); rst = 1'b1;

    // Directed table
    foreach (tbl[i]) begin
      start_op(tbl[i].a, tbl[i].b, tbl[i].rnd);
      wait_valid(lat, bok);
      check($sformatf("tbl%0d_result", i), result_o, tbl[i].r);
      check($sformatf("tbl%0d_flags", i), 32'(flags_o), 32'(tbl[i].f));
      check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
      check($sformatf("tbl%0d_busy", i), 32'(bok), 32'h1);
      release_op();
    end

    // Random against the reference model
    for (int i = 0; i < 250; i++) begin
      logic [31:0] a, b;
      logic        rm;
      a  = rand_op();
      b  = rand_op();
      rm = 1'($urandom_range(0, 1));
      ref_div(a, b, rm, er, ef, el);
      start_op(a, b, rm);
      wait_valid(lat, bok);
      check($sformatf("rand%0d_result(%h/%h,m%0d)", i, a, b, rm), result_o, er);
      check($sformatf("rand%0d_flags", i), 32'(flags_o), 32'(ef));
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'(el));
      release_op();
    end

    // Hold in DONE, then back-to-back start with padv
    start_op(32'h40C00000, 32'h40000000, 1'b0);
    wait_valid(lat, bok);
    r0 = result_o;
    check("b2b_first", r0, 32'h40400000);
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (result_o !== r0 || valid_o !== 1'b1) stable = 1'b0;
    end
    check("hold_stable", 32'(stable), 32'h1);
    @(negedge clk);
    op1_i = 32'h3F800000; op2_i = 32'h40400000; rnd_mode_i = 1'b0;
    start_i = 1'b1; padv_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; padv_i = 1'b0;
    check("b2b_valid_drop", 32'(valid_o), 32'h0);
    check("b2b_busy", 32'(busy_o), 32'h1);
    wait_valid(lat, bok);
    check("b2b_latency", 32'(lat), 32'd28);
    check("b2b_second", result_o, 32'h3EAAAAAB);
    check("b2b_flags", 32'(flags_o), 32'h1);
    release_op();

    // Flush during ITER cycle 10, with a competing start
    start_op(32'h40C00000, 32'h40000000, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk); flush_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1; flush_i = 1'b0; start_i = 1'b0;
    check("flush_valid", 32'(valid_o), 32'h0);
    check("flush_ready", 32'(ready_o), 32'h1);
    check("flush_busy", 32'(busy_o), 32'h0);
    check("flush_result_kept", result_o, 32'h3EAAAAAB);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (valid_o || busy_o) seen++; end
    check("flush_quiet", 32'(seen), 32'h0);
    start_op(32'h40C00000, 32'h40000000, 1'b0);
    wait_valid(lat, bok);
    check("after_flush_result", result_o, 32'h40400000);
    check("after_flush_latency", 32'(lat), 32'd28);
    release_op();

    // Flush in IDLE beats start
    @(negedge clk); flush_i = 1'b1; start_i = 1'b1;
    op1_i = 32'h3F800000; op2_i = 32'h3F800000;
    @(posedge clk); #1; flush_i = 1'b0; start_i = 1'b0;
    check("flush_start_ignored", 32'(busy_o), 32'h0);

    // Asynchronous reset mid-ITER
    start_op(32'h3F800000, 32'h40400000, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk); #2 rst = 1'b0;
    #1;
    check("arst_result", result_o, 32'h0);
    check("arst_flags", 32'(flags_o), 32'h0);
    check("arst_valid", 32'(valid_o), 32'h0);
    check("arst_busy", 32'(busy_o), 32'h0);
    check("arst_ready", 32'(ready_o), 32'h1);
    @(negedge clk); rst = 1'b1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (valid_o) seen++; end
    check("arst_no_valid", 32'(seen), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
